logo_motion_ctrl: RTL and testbench

Per-frame motion scheduler for the bouncing logo sprite in the VGA top level.
- Once per frame, on the vertical-blank tick from the VGA timing generator, it sequences a fixed X-step, Y-step, commit update of the logo origin.
- Outputs are double-buffered, so the pixel datapath only sees a new position during blanking, never mid-frame.
- It reflects direction at screen edges and reports bounce and corner events to the colour/effects logic.

---
 rtl/logo_motion_if.sv | 25 ++
 rtl/logo_motion_ctrl.sv | 164 ++++++++++++++++
 tb/tb_logo_motion_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logo_motion_if.sv
// rtl/logo_motion_if.sv - control and position bundle between the VGA top level and the logo motion scheduler
interface logo_motion_if;
    logic       ena;
    logic       frame_tick;
    logic       pause;
    logic [1:0] speed;
    logic [9:0] logo_x;
    logic [9:0] logo_y;
    logic       dir_x;
    logic       dir_y;
    logic       busy;
    logic       bounce;
    logic       corner;
    logic [2:0] color_idx;

    modport master (
        output ena, frame_tick, pause, speed,
        input  logo_x, logo_y, dir_x, dir_y, busy, bounce, corner, color_idx
    );

    modport slave (
        input  ena, frame_tick, pause, speed,
        output logo_x, logo_y, dir_x, dir_y, busy, bounce, corner, color_idx
    );
endinterface

// File: rtl/logo_motion_ctrl.sv
// rtl/logo_motion_ctrl.sv - per-frame bouncing-logo position scheduler with double-buffered outputs
// Optional colour cycling on bounce is enabled by defining LOGO_COLOR_CYCLE_EN.
module logo_motion_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int LOGO_W   = 64,
    parameter int LOGO_H   = 64,
    parameter int X_INIT   = 288,
    parameter int Y_INIT   = 208
) (
    input  logic          clk,
    input  logic          rst_n,
    logo_motion_if.slave  bus
);

    localparam logic [10:0] XMAX = 11'(H_ACTIVE - LOGO_W);
    localparam logic [10:0] YMAX = 11'(V_ACTIVE - LOGO_H);

    typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, COMMIT} state_t;

    state_t     state, state_nx;
    logic       go;
    logic [2:0] step;
    logic [9:0] sx, sy;
    logic       ndx, ndy, bx, by;
    logic [9:0] logo_x_q, logo_y_q;
    logic       dir_x_q, dir_y_q, busy_q, bounce_q, corner_q;

    logic [10:0] x_sum, y_sum;
    logic [9:0]  sx_step, sy_step;
    logic        ndx_step, ndy_step, bx_hit, by_hit;

    assign go = bus.frame_tick && bus.ena && !bus.pause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = STEP_X;
            STEP_X:  state_nx = STEP_Y;
            STEP_Y:  state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // 11-bit sums keep the limit compare free of wrap-around
    assign x_sum = {1'b0, sx} + {8'b0, step};
    assign y_sum = {1'b0, sy} + {8'b0, step};

    always_comb begin
        sx_step  = sx;
        ndx_step = ndx;
        bx_hit   = 1'b0;
        if (ndx) begin
            if (x_sum >= XMAX) begin
                sx_step  = XMAX[9:0];
                ndx_step = 1'b0;
                bx_hit   = 1'b1;
            end else begin
                sx_step = x_sum[9:0];
            end
        end else if ({1'b0, sx} <= {8'b0, step}) begin
            sx_step  = 10'd0;
            ndx_step = 1'b1;
            bx_hit   = 1'b1;
        end else begin
            sx_step = sx - {7'b0, step};
        end
    end

    always_comb begin
        sy_step  = sy;
        ndy_step = ndy;
        by_hit   = 1'b0;
        if (ndy) begin
            if (y_sum >= YMAX) begin
                sy_step  = YMAX[9:0];
                ndy_step = 1'b0;
                by_hit   = 1'b1;
            end else begin
                sy_step = y_sum[9:0];
            end
        end else if ({1'b0, sy} <= {8'b0, step}) begin
            sy_step  = 10'd0;
            ndy_step = 1'b1;
            by_hit   = 1'b1;
        end else begin
            sy_step = sy - {7'b0, step};
        end
    end

    // Shadow position works ahead; the visible registers move only in COMMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= 3'd1;
            sx       <= 10'(X_INIT);
            sy       <= 10'(Y_INIT);
            ndx      <= 1'b1;
            ndy      <= 1'b1;
            bx       <= 1'b0;
            by       <= 1'b0;
            logo_x_q <= 10'(X_INIT);
            logo_y_q <= 10'(Y_INIT);
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            busy_q   <= 1'b0;
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
        end else begin
            busy_q   <= (state != IDLE);
            bounce_q <= 1'b0;
            corner_q <= 1'b0;
            case (state)
                IDLE: if (go) step <= {1'b0, bus.speed} + 3'd1;
                STEP_X: begin
                    sx  <= sx_step;
                    ndx <= ndx_step;
                    bx  <= bx_hit;
                end
                STEP_Y: begin
                    sy  <= sy_step;
                    ndy <= ndy_step;
                    by  <= by_hit;
                end
                COMMIT: begin
                    logo_x_q <= sx;
                    logo_y_q <= sy;
                    dir_x_q  <= ndx;
                    dir_y_q  <= ndy;
                    bounce_q <= bx | by;
                    corner_q <= bx & by;
                    bx       <= 1'b0;
                    by       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LOGO_COLOR_CYCLE_EN
    logic [2:0] color_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          color_q <= 3'd0;
        else if (state == COMMIT && (bx | by)) color_q <= color_q + 3'd1;
    end
    assign bus.color_idx = color_q;
`else
    assign bus.color_idx = 3'd0;
`endif

    assign bus.logo_x = logo_x_q;
    assign bus.logo_y = logo_y_q;
    assign bus.dir_x  = dir_x_q;
    assign bus.dir_y  = dir_y_q;
    assign bus.busy   = busy_q;
    assign bus.bounce = bounce_q;
    assign bus.corner = corner_q;

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// tb/tb_logo_motion_ctrl.sv - self-checking bench: directed edge cases plus randomized frames against a position model
module tb_logo_motion_ctrl;

    localparam int XMAX = 576;
    localparam int YMAX = 416;
    localparam int NI   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       frame_tick = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] speed = 2'd0;

    logic [9:0] cur_x [NI];
    logic [9:0] cur_y [NI];
    logic       cur_dx [NI];
    logic       cur_dy [NI];
    logic       cur_busy [NI];
    logic       cur_bnc [NI];
    logic       cur_cor [NI];
    logic [2:0] cur_col [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0 at the default origin, 1 near the right edge, 2 one step from the bottom-right corner
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int XI_P = (g == 0) ? 288 : ((g == 1) ? 574 : 575);
        localparam int YI_P = (g == 2) ? 415 : 208;
        logo_motion_if bus ();
        assign bus.ena        = ena;
        assign bus.frame_tick = frame_tick;
        assign bus.pause      = pause;
        assign bus.speed      = speed;
        assign cur_x[g]    = bus.logo_x;
        assign cur_y[g]    = bus.logo_y;
        assign cur_dx[g]   = bus.dir_x;
        assign cur_dy[g]   = bus.dir_y;
        assign cur_busy[g] = bus.busy;
        assign cur_bnc[g]  = bus.bounce;
        assign cur_cor[g]  = bus.corner;
        assign cur_col[g]  = bus.color_idx;
        logo_motion_ctrl #(.X_INIT(XI_P), .Y_INIT(YI_P)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
    end

    // Reference model state
    int xi_m [NI] = '{288, 574, 575};
    int yi_m [NI] = '{208, 208, 415};
    int mx [NI], my [NI], mcol [NI];
    bit mdx [NI], mdy [NI], mbnc [NI], mcor [NI];

    // Captured samples for cycles N..N+4 of a frame window
    logic [9:0] xh [NI][5];
    logic [9:0] yh [NI][5];
    logic       dxh [NI][5];
    logic       dyh [NI][5];
    logic       bh [NI][5];
    logic       boh [NI][5];
    logic       coh [NI][5];
    logic [2:0] colh [NI][5];

    function automatic void axis(input int p, input bit d, input int lim, input int step,
                                 output int np, output bit nd, output bit hit);
        np  = d ? p + step : p - step;
        nd  = d;
        hit = 1'b0;
        if (d && np >= lim) begin
            np = lim; nd = 1'b0; hit = 1'b1;
        end else if (!d && np <= 0) begin
            np = 0; nd = 1'b1; hit = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            mx[i] = xi_m[i]; my[i] = yi_m[i];
            mdx[i] = 1'b1; mdy[i] = 1'b1;
            mcol[i] = 0; mbnc[i] = 1'b0; mcor[i] = 1'b0;
        end
    endfunction

    function automatic void model_frame(input int step);
        int nx, ny;
        bit ndx, ndy, hx, hy;
        for (int i = 0; i < NI; i++) begin
            axis(mx[i], mdx[i], XMAX, step, nx, ndx, hx);
            axis(my[i], mdy[i], YMAX, step, ny, ndy, hy);
            mx[i] = nx; my[i] = ny; mdx[i] = ndx; mdy[i] = ndy;
            mbnc[i] = hx | hy;
            mcor[i] = hx & hy;
`ifdef LOGO_COLOR_CYCLE_EN
            if (hx | hy) mcol[i] = (mcol[i] + 1) % 8;
`endif
        end
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        ena = 1'b1; pause = 1'b0; frame_tick = 1'b0; speed = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // tmask[k] drives frame_tick into edge N+k; samples are taken mid-cycle after each edge
    task automatic run_window(input logic [4:0] tmask, input bit chg_speed);
        logic [5:0] m;
        m = {1'b0, tmask};
        @(posedge clk);
        #1 frame_tick = m[0];
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 frame_tick = m[k+1];
            if (k == 0 && chg_speed) speed = 2'($urandom_range(0, 3));
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                xh[i][k] = cur_x[i];   yh[i][k] = cur_y[i];
                dxh[i][k] = cur_dx[i]; dyh[i][k] = cur_dy[i];
                bh[i][k] = cur_busy[i]; boh[i][k] = cur_bnc[i];
                coh[i][k] = cur_cor[i]; colh[i][k] = cur_col[i];
            end
        end
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1; pause = 1'b0; frame_tick = 1'b0; speed = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (cur_x[0] !== 10'd288) begin errors++; $display("FAIL reset_x got %0d exp 288", cur_x[0]); end
        checks++; if (cur_y[0] !== 10'd208) begin errors++; $display("FAIL reset_y got %0d exp 208", cur_y[0]); end
        checks++; if (cur_dx[0] !== 1'b1 || cur_dy[0] !== 1'b1) begin errors++; $display("FAIL reset_dir got %b%b exp 11", cur_dx[0], cur_dy[0]); end
        checks++; if (cur_busy[0] !== 1'b0 || cur_bnc[0] !== 1'b0 || cur_cor[0] !== 1'b0) begin errors++; $display("FAIL reset_flags got busy %b bounce %b corner %b exp 000", cur_busy[0], cur_bnc[0], cur_cor[0]); end
        checks++; if (cur_col[0] !== 3'd0) begin errors++; $display("FAIL reset_color got %0d exp 0", cur_col[0]); end
        checks++; if (cur_x[1] !== 10'd574) begin errors++; $display("FAIL reset_x_inst1 got %0d exp 574", cur_x[1]); end
    endtask

    task automatic test_basic_step();
        apply_reset();
        speed = 2'd0;
        run_window(5'b00001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bh[0][k] !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL basic_busy cycle N+%0d got %b exp %b", k, bh[0][k], (k >= 1 && k <= 3)); end
        end
        checks++; if (xh[0][2] !== 10'd288) begin errors++; $display("FAIL basic_x_early got %0d exp 288", xh[0][2]); end
        checks++; if (xh[0][3] !== 10'd289) begin errors++; $display("FAIL basic_x got %0d exp 289", xh[0][3]); end
        checks++; if (yh[0][3] !== 10'd209) begin errors++; $display("FAIL basic_y got %0d exp 209", yh[0][3]); end
        checks++; if (boh[0][3] !== 1'b0) begin errors++; $display("FAIL basic_bounce got %b exp 0", boh[0][3]); end
    endtask

    task automatic test_right_edge();
        int ecol;
`ifdef LOGO_COLOR_CYCLE_EN
        ecol = 1;
`else
        ecol = 0;
`endif
        apply_reset();
        speed = 2'd3;
        run_window(5'b00001, 1'b0);
        checks++; if (xh[1][3] !== 10'd576) begin errors++; $display("FAIL edge_x got %0d exp 576", xh[1][3]); end
        checks++; if (dxh[1][3] !== 1'b0) begin errors++; $display("FAIL edge_dir got %b exp 0", dxh[1][3]); end
        checks++; if (boh[1][2] !== 1'b0 || boh[1][3] !== 1'b1 || boh[1][4] !== 1'b0) begin errors++; $display("FAIL edge_bounce_pulse got %b%b%b exp 010", boh[1][2], boh[1][3], boh[1][4]); end
        checks++; if (coh[1][3] !== 1'b0) begin errors++; $display("FAIL edge_corner got %b exp 0", coh[1][3]); end
        checks++; if (colh[1][4] !== 3'(ecol)) begin errors++; $display("FAIL edge_color got %0d exp %0d", colh[1][4], ecol); end
        run_window(5'b00001, 1'b0);
        checks++; if (xh[1][3] !== 10'd572) begin errors++; $display("FAIL edge_return_x got %0d exp 572", xh[1][3]); end
        checks++; if (boh[1][3] !== 1'b0) begin errors++; $display("FAIL edge_return_bounce got %b exp 0", boh[1][3]); end
    endtask

    task automatic test_corner();
        int ecol;
`ifdef LOGO_COLOR_CYCLE_EN
        ecol = 1;
`else
        ecol = 0;
`endif
        apply_reset();
        speed = 2'd0;
        run_window(5'b00001, 1'b0);
        checks++; if (xh[2][3] !== 10'd576 || yh[2][3] !== 10'd416) begin errors++; $display("FAIL corner_pos got %0d,%0d exp 576,416", xh[2][3], yh[2][3]); end
        checks++; if (dxh[2][3] !== 1'b0 || dyh[2][3] !== 1'b0) begin errors++; $display("FAIL corner_dir got %b%b exp 00", dxh[2][3], dyh[2][3]); end
        checks++; if (boh[2][3] !== 1'b1 || coh[2][3] !== 1'b1) begin errors++; $display("FAIL corner_flags got bounce %b corner %b exp 11", boh[2][3], coh[2][3]); end
        checks++; if (colh[2][4] !== 3'(ecol)) begin errors++; $display("FAIL corner_color got %0d exp %0d", colh[2][4], ecol); end
    endtask

    task automatic test_gating();
        apply_reset();
        pause = 1'b1;
        run_window(5'b00001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++; if (bh[0][k] !== 1'b0) begin errors++; $display("FAIL gate_pause_busy cycle N+%0d got %b exp 0", k, bh[0][k]); end
        end
        checks++; if (xh[0][4] !== 10'd288) begin errors++; $display("FAIL gate_pause_x got %0d exp 288", xh[0][4]); end
        pause = 1'b0;
        ena = 1'b0;
        run_window(5'b00001, 1'b0);
        checks++; if (bh[0][1] !== 1'b0 || xh[0][4] !== 10'd288) begin errors++; $display("FAIL gate_ena got busy %b x %0d exp 0 288", bh[0][1], xh[0][4]); end
        ena = 1'b1;
        run_window(5'b00101, 1'b0);
        for (int k = 0; k < 5; k++) begin
            checks++; if (bh[0][k] !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL gate_busy_len cycle N+%0d got %b exp %b", k, bh[0][k], (k >= 1 && k <= 3)); end
        end
        checks++; if (xh[0][4] !== 10'd289) begin errors++; $display("FAIL gate_once_x got %0d exp 289", xh[0][4]); end
        run_window(5'b00000, 1'b0);
        checks++; if (bh[0][1] !== 1'b0 || xh[0][4] !== 10'd289) begin errors++; $display("FAIL gate_not_queued got busy %b x %0d exp 0 289", bh[0][1], xh[0][4]); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        speed = 2'd2;
        run_window(5'b00001, 1'b0);
        @(posedge clk);
        #1 frame_tick = 1'b1;
        @(posedge clk);
        #1 frame_tick = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cur_busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", cur_busy[0]); end
        checks++; if (cur_x[0] !== 10'd288 || cur_y[0] !== 10'd208) begin errors++; $display("FAIL midreset_pos got %0d,%0d exp 288,208", cur_x[0], cur_y[0]); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        speed = 2'd0;
        run_window(5'b00001, 1'b0);
        checks++; if (xh[0][3] !== 10'd289 || yh[0][3] !== 10'd209) begin errors++; $display("FAIL midreset_next got %0d,%0d exp 289,209", xh[0][3], yh[0][3]); end
        checks++; if (bh[0][1] !== 1'b1 || bh[0][4] !== 1'b0) begin errors++; $display("FAIL midreset_busy_seq got %b..%b exp 1..0", bh[0][1], bh[0][4]); end
    endtask

    task automatic test_random_frames();
        int ox [NI], oy [NI], ocol [NI];
        bit odx [NI], ody [NI];
        int sp;
        bit m0, acc;
        logic [2:0] extra;
        apply_reset();
        for (int f = 0; f < 250; f++) begin
            sp    = $urandom_range(0, 3);
            speed = 2'(sp);
            ena   = ($urandom_range(0, 7) != 0);
            pause = ($urandom_range(0, 7) == 0);
            m0    = ($urandom_range(0, 5) != 0);
            extra = m0 ? 3'($urandom_range(0, 7)) : 3'd0;
            acc   = m0 && ena && !pause;
            for (int i = 0; i < NI; i++) begin
                ox[i] = mx[i]; oy[i] = my[i]; odx[i] = mdx[i]; ody[i] = mdy[i]; ocol[i] = mcol[i];
            end
            run_window({1'b0, extra, m0}, 1'b1);
            if (acc) model_frame(sp + 1);
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < 5; k++) begin
                    bit nw;
                    nw = acc && (k >= 3);
                    checks++; if (xh[i][k] !== 10'(nw ? mx[i] : ox[i])) begin errors++; $display("FAIL rand_x f%0d i%0d k%0d got %0d exp %0d", f, i, k, xh[i][k], nw ? mx[i] : ox[i]); end
                    checks++; if (yh[i][k] !== 10'(nw ? my[i] : oy[i])) begin errors++; $display("FAIL rand_y f%0d i%0d k%0d got %0d exp %0d", f, i, k, yh[i][k], nw ? my[i] : oy[i]); end
                    checks++; if (dxh[i][k] !== (nw ? mdx[i] : odx[i]) || dyh[i][k] !== (nw ? mdy[i] : ody[i])) begin errors++; $display("FAIL rand_dir f%0d i%0d k%0d got %b%b", f, i, k, dxh[i][k], dyh[i][k]); end
                    checks++; if (bh[i][k] !== (acc && k >= 1 && k <= 3)) begin errors++; $display("FAIL rand_busy f%0d i%0d k%0d got %b exp %b", f, i, k, bh[i][k], (acc && k >= 1 && k <= 3)); end
                    checks++; if (boh[i][k] !== (acc && k == 3 && mbnc[i])) begin errors++; $display("FAIL rand_bounce f%0d i%0d k%0d got %b exp %b", f, i, k, boh[i][k], (acc && k == 3 && mbnc[i])); end
                    checks++; if (coh[i][k] !== (acc && k == 3 && mcor[i])) begin errors++; $display("FAIL rand_corner f%0d i%0d k%0d got %b exp %b", f, i, k, coh[i][k], (acc && k == 3 && mcor[i])); end
                    checks++; if (colh[i][k] !== 3'(nw ? mcol[i] : ocol[i])) begin errors++; $display("FAIL rand_color f%0d i%0d k%0d got %0d exp %0d", f, i, k, colh[i][k], nw ? mcol[i] : ocol[i]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_step();
        test_right_edge();
        test_corner();
        test_gating();
        test_reset_mid();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
